uart_tx_ctrl: RTL and testbench

Transmit sequencer directly upstream of the UART parallel-in/serial-out shift register.
- Accepts bytes over a valid/ready interface into a small internal FIFO.
- Computes parity and drives the shift register's load/shift/parity/data inputs to emit 8N-parity-1 frames: start, d0..d7, parity, stop.
- reg_clk is the bit clock: one reg_clk cycle equals one bit time, the same clock as the shift register.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_tx_fifo.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 111 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, widths and parity helper for the UART transmit sequencer
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int FRAME_SHIFTS = 10;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, BREAK} state_t;
  function automatic logic parity_calc(input logic [DATA_W-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting to be framed
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     reg_clk,
  input  logic                     reg_rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage array, no reset needed since count gates every read
  always_ff @(posedge reg_clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge reg_clk)
    if (!reg_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer driving the UART shift register; UART_TX_BREAK_EN adds break_req/BREAK
module uart_tx_ctrl import uart_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic                     reg_clk,
  input  logic                     reg_rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_req,
`endif
  input  logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic                     parity_odd,
  output logic                     load,
  output logic                     shift,
  output logic                     parity_bit,
  output logic [DATA_W-1:0]        p_data_out,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int GAP_LEN = IDLE_GAP > 0 ? IDLE_GAP : 1;
  localparam int CW = $clog2((FRAME_SHIFTS > GAP_LEN ? FRAME_SHIFTS : GAP_LEN) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] head, pdata_n;
  logic full, empty, push, pop;
  logic load_n, shift_n, done_n, busy_n, par_n;
  assign tx_ready = !full;
  assign push = tx_valid && !full;
  assign pop = state == LOAD;
  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .reg_clk(reg_clk),
    .reg_rst_n(reg_rst_n),
    .push(push),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // next state and next values of the registered shift-register controls
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    load_n = 1'b0;
    shift_n = 1'b0;
    done_n = 1'b0;
    busy_n = state != IDLE;
    pdata_n = p_data_out;
    par_n = parity_bit;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        state_n = break_req ? BREAK : empty ? IDLE : LOAD;
`else
        state_n = empty ? IDLE : LOAD;
`endif
      end
      LOAD: begin
        load_n = 1'b1;
        pdata_n = head;
        par_n = parity_calc(head, parity_odd);
        cnt_n = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        shift_n = 1'b1;
        done_n = cnt == CW'(FRAME_SHIFTS - 1);
        cnt_n = done_n ? '0 : cnt + 1'b1;
        if (done_n) state_n = IDLE_GAP > 0 ? GAP : empty ? IDLE : LOAD;
      end
      GAP: begin
        cnt_n = cnt == CW'(GAP_LEN - 1) ? '0 : cnt + 1'b1;
        if (cnt == CW'(GAP_LEN - 1)) state_n = empty ? IDLE : LOAD;
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        load_n = 1'b1;
        pdata_n = '0;
        cnt_n = '0;
        state_n = break_req ? BREAK : GAP;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  // state, counter and registered outputs
  always_ff @(posedge reg_clk)
    if (!reg_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      load <= 1'b0;
      shift <= 1'b0;
      parity_bit <= 1'b0;
      p_data_out <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      load <= load_n;
      shift <= shift_n;
      parity_bit <= par_n;
      p_data_out <= pdata_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl (IDLE_GAP=0 and IDLE_GAP=2 instances)
module tb_uart_tx_ctrl;
  logic reg_clk = 1'b0;
  logic reg_rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0, tx_valid2 = 1'b0, parity_odd = 1'b0;
  logic tx_ready, load, shift, parity_bit, tx_busy, tx_done;
  logic [7:0] p_data_out;
  logic [2:0] fifo_count;
  logic tx_ready2, load2, shift2, parity_bit2, tx_busy2, tx_done2;
  logic [7:0] p_data_out2;
  logic [2:0] fifo_count2;
`ifdef UART_TX_BREAK_EN
  logic break_req = 1'b0;
`endif
  int n_tests = 0, n_fail = 0, cyc = 0, ready_err = 0, max_cnt = 0;
  logic [7:0] lq_d[$];
  int lq_t[$];

  always #5 reg_clk = ~reg_clk;

  uart_tx_ctrl #(.DEPTH(4), .IDLE_GAP(0)) u0 (
    .reg_clk(reg_clk), .reg_rst_n(reg_rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .parity_odd(parity_odd),
    .load(load), .shift(shift), .parity_bit(parity_bit), .p_data_out(p_data_out),
    .tx_busy(tx_busy), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  uart_tx_ctrl #(.DEPTH(4), .IDLE_GAP(2)) u2 (
    .reg_clk(reg_clk), .reg_rst_n(reg_rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .parity_odd(parity_odd),
    .load(load2), .shift(shift2), .parity_bit(parity_bit2), .p_data_out(p_data_out2),
    .tx_busy(tx_busy2), .tx_done(tx_done2), .fifo_count(fifo_count2)
  );

  // record every load pulse of u0 and watch tx_ready against the FIFO fill level
  always @(posedge reg_clk) begin
    cyc++;
    #1;
    if (load) begin
      lq_d.push_back(p_data_out);
      lq_t.push_back(cyc);
    end
    if (tx_ready !== (fifo_count != 3'd4)) ready_err++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  task automatic step();
    @(posedge reg_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v[6], input int n, output int rej);
    int i = 0;
    int g = 0;
    logic acc;
    rej = 0;
    tx_valid = 1'b1;
    while (i < n && g < 40) begin
      tx_data = v[i];
      acc = tx_ready;
      step();
      if (acc) i++;
      else rej++;
      g++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_load(input int max);
    int n = 0;
    while (!load && n < max) begin
      step();
      n++;
    end
    chk("wait_load", {31'd0, load}, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((tx_busy || fifo_count != 0 || shift || load) && n < max) begin
      step();
      n++;
    end
    chk("wait_idle", {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] v[6];
    int rej, sh, dn, dn_at, n;
    // reset state
    step();
    step();
    chk("rst_load", {31'd0, load}, 32'd0);
    chk("rst_shift", {31'd0, shift}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_pdata", {24'd0, p_data_out}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    reg_rst_n = 1'b1;
    step();
    // single byte, even parity, latency and frame length
    v = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(v, 1, rej);
    chk("a5_count", {29'd0, fifo_count}, 32'd1);
    chk("a5_load_k", {31'd0, load}, 32'd0);
    step();
    chk("a5_load_k1", {31'd0, load}, 32'd0);
    step();
    chk("a5_load_k2", {31'd0, load}, 32'd1);
    chk("a5_pdata", {24'd0, p_data_out}, 32'hA5);
    chk("a5_parity", {31'd0, parity_bit}, 32'd0);
    chk("a5_busy", {31'd0, tx_busy}, 32'd1);
    chk("a5_popped", {29'd0, fifo_count}, 32'd0);
    sh = 0;
    dn = 0;
    dn_at = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (shift && !load) sh++;
      if (tx_done) begin
        dn++;
        dn_at = i;
      end
    end
    chk("a5_shifts", sh, 32'd10);
    chk("a5_done_n", dn, 32'd1);
    chk("a5_done_at", dn_at, 32'd9);
    step();
    chk("a5_shift_end", {31'd0, shift}, 32'd0);
    chk("a5_busy_end", {31'd0, tx_busy}, 32'd0);
    chk("a5_pdata_hold", {24'd0, p_data_out}, 32'hA5);
    // odd parity
    parity_odd = 1'b1;
    v[0] = 8'h01;
    send(v, 1, rej);
    wait_load(5);
    chk("p01_data", {24'd0, p_data_out}, 32'h01);
    chk("p01_parity", {31'd0, parity_bit}, 32'd0);
    wait_idle(20);
    v[0] = 8'h03;
    send(v, 1, rej);
    wait_load(5);
    chk("p03_data", {24'd0, p_data_out}, 32'h03);
    chk("p03_parity", {31'd0, parity_bit}, 32'd1);
    wait_idle(20);
    // four bytes back to back
    lq_d.delete();
    lq_t.delete();
    v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    send(v, 4, rej);
    chk("b2b_rej", rej, 32'd0);
    wait_idle(60);
    chk("b2b_nloads", lq_d.size(), 32'd4);
    if (lq_d.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("b2b_data%0d", i), {24'd0, lq_d[i]}, {24'd0, v[i]});
        if (i > 0) chk($sformatf("b2b_gap%0d", i), lq_t[i] - lq_t[i-1], 32'd11);
      end
    // overfill: 5th and 6th byte must wait for a pop
    lq_d.delete();
    lq_t.delete();
    v = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    send(v, 6, rej);
    chk("full_rej", rej, 32'd9);
    chk("full_max", max_cnt, 32'd4);
    wait_idle(100);
    chk("full_nloads", lq_d.size(), 32'd6);
    if (lq_d.size() == 6)
      for (int i = 0; i < 6; i++) chk($sformatf("full_data%0d", i), {24'd0, lq_d[i]}, {24'd0, v[i]});
    // IDLE_GAP=2 instance: two idle bit times between stop shift and next load
    tx_data = 8'h5A;
    tx_valid2 = 1'b1;
    step();
    tx_data = 8'h3C;
    step();
    tx_valid2 = 1'b0;
    n = 0;
    while (!tx_done2 && n < 30) begin
      step();
      n++;
    end
    chk("gap_done", {31'd0, tx_done2}, 32'd1);
    step();
    chk("gap1_ls", {30'd0, load2, shift2}, 32'd0);
    step();
    chk("gap2_ls", {30'd0, load2, shift2}, 32'd0);
    step();
    chk("gap_load", {31'd0, load2}, 32'd1);
    chk("gap_pdata", {24'd0, p_data_out2}, 32'h3C);
    // reset in the middle of a frame
    lq_d.delete();
    lq_t.delete();
    v = '{8'hC3, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00};
    send(v, 3, rej);
    chk("mid_load", {31'd0, load}, 32'd1);
    chk("mid_parity", {31'd0, parity_bit}, 32'd1);
    repeat (4) step();
    chk("mid_shift", {31'd0, shift}, 32'd1);
    chk("mid_count", {29'd0, fifo_count}, 32'd2);
    reg_rst_n = 1'b0;
    step();
    reg_rst_n = 1'b1;
    chk("mid_rst_outs", {29'd0, load, shift, tx_done}, 32'd0);
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mid_rst_pp", {23'd0, parity_bit, p_data_out}, 32'd0);
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    repeat (15) step();
    chk("mid_no_reload", lq_d.size(), 32'd1);
    chk("ready_vs_full", ready_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
